// File: rtl/stage_chain_sequencer_pkg.sv
// Shared constants for the stage chain sequencer: FSM encoding, stage kinds
// and the width of the stage index counter.
package stage_seq_pkg;

  localparam int IDX_W = 5;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

  localparam logic KIND_M31 = 1'b0;
  localparam logic KIND_M32 = 1'b1;

endpackage

// File: rtl/mod31.sv
// Even chain stage. While the run flag is set it rotates the operand left by
// five and adds 31; the flag survives only if the operand is not a multiple
// of 31. With the flag clear the operand passes through untouched.
module mod31 #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] num,
  input  logic             rin,
  output logic [WIDTH-1:0] num_o,
  output logic             rout
);

  logic [WIDTH-1:0] w_rot;
  logic [WIDTH-1:0] w_res;

  assign w_rot = {num[WIDTH-6:0], num[WIDTH-1:WIDTH-5]};
  assign w_res = num % WIDTH'(31);

  assign num_o = rin ? (w_rot + WIDTH'(31)) : num;
  assign rout  = rin && (w_res != '0);

endmodule

// File: rtl/mod32.sv
// Odd chain stage. While the run flag is set it folds the operand with a
// 7-bit right shift of itself and adds 32; the flag survives only if the
// operand is not a multiple of 32. With the flag clear it passes through.
module mod32 #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] num,
  input  logic             rin,
  output logic [WIDTH-1:0] num_o,
  output logic             rout
);

  logic [WIDTH-1:0] w_mix;

  assign w_mix = num ^ (num >> 7);

  assign num_o = rin ? (w_mix + WIDTH'(32)) : num;
  assign rout  = rin && (num[4:0] != 5'd0);

endmodule

// File: rtl/stage_chain_sequencer_stage_pair_unit.sv
// One mod31 and one mod32 evaluated side by side on the same operand; the
// stage kind picks which result goes back to the accumulator. Combinational.
module stage_pair_unit
  import stage_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] num,
  input  logic             rin,
  input  logic             kind,
  output logic [WIDTH-1:0] num_o,
  output logic             rout
);

  logic [WIDTH-1:0] w_m31_num;
  logic [WIDTH-1:0] w_m32_num;
  logic             w_m31_rout;
  logic             w_m32_rout;

  mod31 #(.WIDTH(WIDTH)) u_mod31 (
    .num   (num),
    .rin   (rin),
    .num_o (w_m31_num),
    .rout  (w_m31_rout)
  );

  mod32 #(.WIDTH(WIDTH)) u_mod32 (
    .num   (num),
    .rin   (rin),
    .num_o (w_m32_num),
    .rout  (w_m32_rout)
  );

  assign num_o = (kind == KIND_M32) ? w_m32_num  : w_m31_num;
  assign rout  = (kind == KIND_M32) ? w_m32_rout : w_m31_rout;

endmodule

// File: rtl/stage_chain_sequencer.sv
// Time-multiplexed replacement for the unrolled mod31/mod32 chain: one
// operand is accepted, stepped through STAGES alternating stage evaluations
// (one per cycle) and then held on the output until the consumer takes it.
module stage_chain_sequencer
  import stage_seq_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int STAGES     = 18,
  parameter int EARLY_EXIT = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_num,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_num,
  output logic             out_flag,
  output logic [IDX_W-1:0] out_stages,
  output logic             busy
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(STAGES - 1);
  localparam logic             EE_EN    = (EARLY_EXIT != 0);

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_acc;
  logic             r_flag;
  logic [IDX_W-1:0] r_idx;

  logic [WIDTH-1:0] w_num_o;
  logic             w_rout;
  logic             w_last;

  // Even index runs mod31, odd index runs mod32.
  stage_pair_unit #(.WIDTH(WIDTH)) u_stage (
    .num   (r_acc),
    .rin   (r_flag),
    .kind  (r_idx[0]),
    .num_o (w_num_o),
    .rout  (w_rout)
  );

  // The current stage ends the sequence on the final index, or early when
  // early exit is enabled and the run flag has just dropped.
  assign w_last = (r_idx == LAST_IDX) || (EE_EN && !w_rout);

  // FSM plus operand/flag/index registers; reset discards any in-flight work.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_acc   <= '0;
      r_flag  <= 1'b0;
      r_idx   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_acc   <= in_num;
            r_flag  <= 1'b1;
            r_idx   <= '0;
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_acc  <= w_num_o;
          r_flag <= w_rout;
          r_idx  <= r_idx + IDX_W'(1);
          if (w_last) begin
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready   = (r_state == ST_IDLE);
  assign out_valid  = (r_state == ST_DONE);
  assign busy       = (r_state != ST_IDLE);
  assign out_num    = r_acc;
  assign out_flag   = r_flag;
  assign out_stages = r_idx;

endmodule

// File: tb/tb_stage_chain_sequencer.sv
// Self-checking bench: three sequencer instances (18 stages, 18 stages with
// early exit, 1 stage) checked against a behavioural chain model.
module tb_stage_chain_sequencer;

  typedef struct {
    logic [31:0] num;
    logic        flag;
    int          count;
  } res_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid   [3];
  logic        in_ready   [3];
  logic [31:0] in_num     [3];
  logic        out_valid  [3];
  logic        out_ready  [3];
  logic [31:0] out_num    [3];
  logic        out_flag   [3];
  logic [4:0]  out_stages [3];
  logic        busy       [3];

  int checks = 0;
  int errors = 0;
  int cyc_cnt = 0;
  int acc_cyc;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_dut
      stage_chain_sequencer #(
        .WIDTH      (32),
        .STAGES     ((gi == 2) ? 1 : 18),
        .EARLY_EXIT ((gi == 1) ? 1 : 0)
      ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid[gi]),
        .in_ready   (in_ready[gi]),
        .in_num     (in_num[gi]),
        .out_valid  (out_valid[gi]),
        .out_ready  (out_ready[gi]),
        .out_num    (out_num[gi]),
        .out_flag   (out_flag[gi]),
        .out_stages (out_stages[gi]),
        .busy       (busy[gi])
      );
    end
  endgenerate

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // Behavioural chain: even stages mod31, odd stages mod32, run flag carried.
  function automatic res_t model(input logic [31:0] n, input int stages, input bit ee);
    res_t r;
    logic [31:0] nx;
    logic fx;
    r.num = n;
    r.flag = 1'b1;
    r.count = 0;
    for (int k = 0; k < stages; k++) begin
      if (k % 2 == 0) begin
        nx = r.flag ? (((r.num << 5) | (r.num >> 27)) + 32'd31) : r.num;
        fx = r.flag && ((r.num % 32'd31) != 32'd0);
      end else begin
        nx = r.flag ? ((r.num ^ (r.num >> 7)) + 32'd32) : r.num;
        fx = r.flag && ((r.num % 32'd32) != 32'd0);
      end
      r.num = nx;
      r.flag = fx;
      r.count = k + 1;
      if (ee && !fx) break;
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction on instance u: accept, run, optional backpressure,
  // drain. With poke set, in_valid stays high carrying 32'hDEADBEEF after
  // the accept so the next call's operand is already being offered.
  task automatic run_op(input int u, input logic [31:0] opnd, input int stages,
                        input bit ee, input int hold, input bit poke);
    res_t m;
    int cyc;
    m = model(opnd, stages, ee);
    cyc = 0;
    while (in_ready[u] !== 1'b1 && cyc < 50) begin
      tick();
      cyc++;
    end
    check("in_ready_before_accept", 64'(in_ready[u]), 64'd1);
    out_ready[u] = (hold == 0);
    in_valid[u]  = 1'b1;
    in_num[u]    = opnd;
    tick();
    acc_cyc = cyc_cnt;
    check("busy_after_accept", 64'(busy[u]), 64'd1);
    check("in_ready_in_run", 64'(in_ready[u]), 64'd0);
    if (poke) in_num[u] = 32'hDEAD_BEEF;
    else      in_valid[u] = 1'b0;
    cyc = 0;
    while (out_valid[u] !== 1'b1 && cyc < 64) begin
      if (cyc > 0) check("in_ready_low_while_busy", 64'(in_ready[u]), 64'd0);
      tick();
      cyc++;
    end
    check("latency", 64'(cyc), 64'(m.count));
    check("out_num", 64'(out_num[u]), 64'(m.num));
    check("out_flag", 64'(out_flag[u]), 64'(m.flag));
    check("out_stages", 64'(out_stages[u]), 64'(m.count));
    for (int i = 0; i < hold; i++) begin
      tick();
      check("hold_valid", 64'(out_valid[u]), 64'd1);
      check("hold_num", 64'(out_num[u]), 64'(m.num));
      check("hold_flag", 64'(out_flag[u]), 64'(m.flag));
      check("hold_stages", 64'(out_stages[u]), 64'(m.count));
      check("hold_in_ready", 64'(in_ready[u]), 64'd0);
    end
    out_ready[u] = 1'b1;
    tick();
    check("drain_valid", 64'(out_valid[u]), 64'd0);
    check("drain_in_ready", 64'(in_ready[u]), 64'd1);
    $display("TXN unit=%0d in=%h out=%h flag=%0d stages=%0d lat=%0d hold=%0d",
             u, opnd, m.num, m.flag, m.count, cyc, hold);
  endtask

  initial begin
    res_t m;
    logic [31:0] op;
    int first_acc;
    int found;

    rst_n = 1'b0;
    for (int u = 0; u < 3; u++) begin
      in_valid[u]  = 1'b0;
      in_num[u]    = '0;
      out_ready[u] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();

    // Reset state
    for (int u = 0; u < 3; u++) begin
      check("reset_in_ready", 64'(in_ready[u]), 64'd1);
      check("reset_out_valid", 64'(out_valid[u]), 64'd0);
      check("reset_busy", 64'(busy[u]), 64'd0);
      check("reset_out_num", 64'(out_num[u]), 64'd0);
      check("reset_out_stages", 64'(out_stages[u]), 64'd0);
    end

    // Golden operands, out_ready high throughout
    run_op(0, 32'h0000_0001, 18, 1'b0, 0, 1'b0);
    run_op(0, 32'hFFFF_FFFF, 18, 1'b0, 0, 1'b0);
    run_op(0, 32'h1234_5678, 18, 1'b0, 0, 1'b0);

    // Backpressure
    run_op(0, 32'hCAFE_0123, 18, 1'b0, 5, 1'b0);

    // Busy rejection: DEADBEEF offered all through, accepted only afterwards
    run_op(0, 32'h0BAD_F00D, 18, 1'b0, 2, 1'b1);
    run_op(0, 32'hDEAD_BEEF, 18, 1'b0, 0, 1'b0);

    // Random operands
    for (int i = 0; i < 6; i++) begin
      run_op(0, $urandom, 18, 1'b0, int'($urandom_range(0, 3)), 1'b0);
    end

    // Reset mid-run at idx 7
    in_valid[0] = 1'b1;
    in_num[0]   = 32'h5555_AAAA;
    out_ready[0] = 1'b1;
    tick();
    in_valid[0] = 1'b0;
    repeat (7) tick();
    check("pre_reset_busy", 64'(busy[0]), 64'd1);
    rst_n = 1'b0;
    #1;
    check("midrun_reset_busy", 64'(busy[0]), 64'd0);
    check("midrun_reset_out_valid", 64'(out_valid[0]), 64'd0);
    check("midrun_reset_in_ready", 64'(in_ready[0]), 64'd1);
    #2;
    rst_n = 1'b1;
    tick();
    $display("TXN unit=0 reset asserted mid-run at idx=7");
    run_op(0, 32'h7777_1111, 18, 1'b0, 0, 1'b0);

    // Early exit: drop at stage 0 (multiple of 31)
    run_op(1, 32'd31 * 32'd12345, 18, 1'b1, 0, 1'b0);
    // Early exit: search for a drop somewhere past stage 0
    found = 0;
    op = 32'h0;
    for (int t = 0; t < 4000 && found == 0; t++) begin
      op = $urandom;
      m = model(op, 18, 1'b1);
      if (!m.flag && m.count > 1) found = 1;
    end
    check("early_exit_operand_found", 64'(found), 64'd1);
    run_op(1, op, 18, 1'b1, 1, 1'b0);
    // Early exit instance with operands that may or may not drop
    for (int i = 0; i < 4; i++) begin
      run_op(1, $urandom, 18, 1'b1, 0, 1'b0);
    end

    // Minimum depth: single mod31 stage, initiation interval of 3
    run_op(2, 32'h0000_00F8, 1, 1'b0, 0, 1'b0);
    first_acc = acc_cyc;
    run_op(2, 32'h8000_0001, 1, 1'b0, 0, 1'b0);
    check("min_depth_ii", 64'(acc_cyc - first_acc), 64'd3);
    run_op(2, 32'd31 * 32'd7, 1, 1'b0, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stage_chain_sequencer.md
# stage_chain_sequencer

Iterative controller that replaces the unrolled 18-stage `mod31`/`mod32` chain with a single time-multiplexed stage pair. It sequences one 32-bit operand through `STAGES` alternating stage evaluations, carrying the 1-bit run flag (`rin`→`rout`) between them. It presents valid/ready handshakes on input and output. It sits between the operand source and the result consumer wherever the unrolled top is too large.

## Interface
- `WIDTH`, 32, operand width; must match `mod31`/`mod32` `num` width.
- `STAGES`, 18, total stage evaluations. Legal range 1..31. Even index uses `mod31`; odd index uses `mod32`.
- `EARLY_EXIT`, 0. When 1, the sequence stops as soon as a stage returns `rout`=0.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  operand offered.
- `in_ready`  out  1  block can accept an operand.
- `in_num`  in  WIDTH  operand; sampled on accept.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer takes the result.
- `out_num`  out  WIDTH  final operand value (`num_o` of the last executed stage).
- `out_flag`  out  1  final run flag (`rout` of the last executed stage).
- `out_stages`  out  5  number of stages executed, 1..STAGES.
- `busy`  out  1  high in RUN and DONE.

## Operation
- FSM states are IDLE, RUN and DONE.
- IDLE
  - `in_ready`=1.
  - On `in_valid && in_ready`: `acc`←`in_num`, `flag`←1, `idx`←0, go to RUN.
- RUN
  - The stage unit is fed `acc`, `flag` and `idx[0]`. `idx[0]`=0 selects `mod31`; `idx[0]`=1 selects `mod32`.
  - Each cycle: `acc`←`num_o`, `flag`←`rout`, `idx`←`idx`+1.
  - If `idx`==STAGES-1, go to DONE.
  - Else, if EARLY_EXIT=1 and `rout`=0, go to DONE.
- DONE
  - `out_valid`=1.
  - `out_num`=`acc`, `out_flag`=`flag`, `out_stages`=`idx`. These are held stable until `out_ready`.
  - On `out_ready`, go to IDLE.
- `in_ready` is low in RUN and DONE. `in_valid` in those states is ignored, not queued.
- `out_valid` does not depend combinationally on `out_ready`. `in_ready` is a decode of state only.
- Equivalence: with EARLY_EXIT=0 and STAGES=18, `out_num` equals `w1[17]` and `out_flag` equals `w2[17]` of the unrolled chain driven with `rin`=1.
- Widths
  - `idx` is 5 bits and never exceeds STAGES.
  - No arithmetic is performed on `acc`; it is a pure register of stage output.
- Reset (at any time, including mid-RUN or in DONE)
  - State→IDLE; `acc`, `flag`, `idx`→0.
  - `out_valid`=0, `busy`=0, `in_ready`=1 immediately (asynchronous).
  - The in-flight operand is discarded; no partial result is emitted.

## Timing
- The accept edge is cycle 0. RUN then occupies cycles 1..STAGES.
- `out_valid` rises after edge STAGES (EARLY_EXIT=0). With early exit it rises after the edge of the terminating stage.
- Minimum initiation interval is STAGES+2 cycles, because DONE and IDLE each take at least one cycle.
- If `out_ready` is high on the first DONE cycle, DONE lasts exactly one cycle.
- The stage unit is combinational in RUN. Its path, mux → `mod31`/`mod32` → `acc`, is the critical path. No extra pipeline register is allowed, so one stage completes per cycle.

## Structure
- Package `stage_seq_pkg` holds:
  - the state encoding (IDLE=2'b00, RUN=2'b01, DONE=2'b10);
  - stage kind constants (`KIND_M31`=0, `KIND_M32`=1);
  - `IDX_W`=5.
- Sub-module `stage_pair_unit`:
  - instantiates one `mod31` and one `mod32`;
  - muxes their `num_o`/`rout` by a `kind` select;
  - is purely combinational.
- The top holds the FSM, the `acc`/`flag`/`idx` registers and the handshake logic.

## Test plan
- Golden match: `in_num`=32'h0000_0001, then 32'hFFFF_FFFF, then 32'h1234_5678. `out_ready`=1 throughout. Require `out_num`/`out_flag` equal to the unrolled 18-stage chain outputs, `out_stages`=18, and `out_valid` exactly 18 cycles after each accept.
- Backpressure: hold `out_ready`=0 for 5 cycles in DONE. Require `out_valid`=1 and `out_num`, `out_flag`, `out_stages` unchanged for all 5 cycles. Require `in_ready`=0 until the cycle after `out_ready`=1.
- Busy rejection: assert `in_valid` with 32'hDEAD_BEEF throughout RUN. Require the accepted operand's result to be unaffected and 32'hDEAD_BEEF accepted only on return to IDLE.
- Reset mid-run: deassert `rst_n` at `idx`=7. Require an immediate `busy`=0, `out_valid`=0 and `in_ready`=1. After release, a new operand must produce the correct 18-stage result.
- Early exit: EARLY_EXIT=1, with an operand for which the golden chain drops `rout` at stage k. Require `out_stages`=k+1, `out_flag`=0 and `out_num`=chain `w1[k]`.
- Minimum depth: STAGES=1. Require a single `mod31` evaluation, `out_valid` 1 cycle after accept, and an initiation interval of 3 cycles.
